// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter_pkg : shared types and round-robin helper for dmem_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    BREAK  = 2'd2
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_UART = 1'b1;

  // Grant vector: bit 0 = core, bit 1 = loader. On a tie the port that did
  // not win last time takes the grant.
  function automatic logic [1:0] rr_pick(input logic req_c, input logic req_u, input logic last);
    rr_pick = (req_c && req_u) ? ((last == PORT_UART) ? 2'b01 : 2'b10) : {req_u, req_c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter : round-robin arbiter sharing one data-memory port between the
//                core load/store unit and the UART loader, with watchdog lock.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 256
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          i_req_c,
  input  logic          i_we_c,
  input  logic [AW-1:0] i_addr_c,
  input  logic [DW-1:0] i_wdata_c,
  input  logic [3:0]    i_be_c,
  output logic          o_gnt_c,
  output logic          o_rvalid_c,
  output logic [DW-1:0] o_rdata_c,

  input  logic          i_req_u,
  input  logic          i_we_u,
  input  logic [AW-1:0] i_addr_u,
  input  logic [DW-1:0] i_wdata_u,
  input  logic [3:0]    i_be_u,
  output logic          o_gnt_u,
  output logic          o_rvalid_u,
  output logic [DW-1:0] o_rdata_u,

  input  logic          i_lock_u,
  output logic          o_lock_err,

  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int            CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] C_LOCK_LIM = CW'(LOCK_MAX);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } mem_req_t;

  arb_state_t    r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt, w_lock_cnt_inc;
  logic          r_lock_err, w_lock_err_nxt;
  logic          r_rd_pend, r_rd_owner;
  logic [1:0]    w_gnt;
  mem_req_t      w_sel;

  assign w_lock_cnt_inc = r_lock_cnt + CW'(1);

  always_comb begin
    w_gnt          = 2'b00;
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_lock_err_nxt = r_lock_err;
    case (r_state)
      ARB: begin
        w_gnt = rr_pick(i_req_c, i_req_u, r_last);
        if (i_lock_u) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        w_gnt = {i_req_u, 1'b0};
        // Releasing the lock takes priority over the watchdog firing.
        if (!i_lock_u) begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = '0;
        end else if (i_req_c) begin
          w_lock_cnt_nxt = w_lock_cnt_inc;
          if (w_lock_cnt_inc == C_LOCK_LIM) w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        w_gnt          = {1'b0, i_req_c};
        w_lock_err_nxt = 1'b1;
        w_lock_cnt_nxt = '0;
        w_state_nxt    = i_lock_u ? LOCKED : ARB;
      end
      default: begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_sel = '0;
    case (w_gnt)
      2'b01:   w_sel = '{we: i_we_c, addr: i_addr_c, wdata: i_wdata_c, be: i_be_c};
      2'b10:   w_sel = '{we: i_we_u, addr: i_addr_u, wdata: i_wdata_u, be: i_be_u};
      default: w_sel = '0;
    endcase
  end

  assign w_last_nxt = (|w_gnt) ? w_gnt[1] : r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_last     <= PORT_UART;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= PORT_CORE;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_lock_err <= w_lock_err_nxt;
      r_rd_pend  <= (|w_gnt) & ~w_sel.we;
      r_rd_owner <= w_gnt[1];
    end
  end

  // Grants and strobes are forced low while reset is held, since requests
  // may still be asserted by upstream logic that is not yet reset.
  assign o_gnt_c     = w_gnt[0] & rst_n;
  assign o_gnt_u     = w_gnt[1] & rst_n;
  assign o_mem_en    = (|w_gnt) & rst_n;
  assign o_mem_we    = w_sel.we & rst_n;
  assign o_mem_addr  = w_sel.addr;
  assign o_mem_wdata = w_sel.wdata;
  assign o_mem_be    = w_sel.be;

  assign o_rvalid_c  = r_rd_pend & (r_rd_owner == PORT_CORE);
  assign o_rvalid_u  = r_rd_pend & (r_rd_owner == PORT_UART);
  assign o_rdata_c   = i_mem_rdata;
  assign o_rdata_u   = i_mem_rdata;
  assign o_lock_err  = r_lock_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : directed bench with read-response scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_c, we_c, req_u, we_u, lock_u;
  logic [31:0] addr_c, wdata_c, addr_u, wdata_u;
  logic [3:0]  be_c, be_u;
  logic        gnt_c, gnt_u, rvalid_c, rvalid_u, lock_err;
  logic [31:0] rdata_c, rdata_u;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_c(req_c), .i_we_c(we_c), .i_addr_c(addr_c), .i_wdata_c(wdata_c), .i_be_c(be_c),
    .o_gnt_c(gnt_c), .o_rvalid_c(rvalid_c), .o_rdata_c(rdata_c),
    .i_req_u(req_u), .i_we_u(we_u), .i_addr_u(addr_u), .i_wdata_u(wdata_u), .i_be_u(be_u),
    .o_gnt_u(gnt_u), .o_rvalid_u(rvalid_u), .o_rdata_u(rdata_u),
    .i_lock_u(lock_u), .o_lock_err(lock_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: an entry stamped in cycle N is due in cycle N+1.
  logic        m_erc, m_eru;
  logic [31:0] m_ed;
  always @(posedge clk) begin
    #2;
    m_erc = 1'b0;
    m_eru = 1'b0;
    m_ed  = '0;
    if (q.size() > 0 && q[0].cyc == cyc - 1) begin
      m_erc = (q[0].owner == 1'b0);
      m_eru = (q[0].owner == 1'b1);
      m_ed  = q[0].data;
      void'(q.pop_front());
    end
    chk("rvalid_c", rvalid_c, m_erc);
    chk("rvalid_u", rvalid_u, m_eru);
    if (m_erc) chk("rdata_c", rdata_c, m_ed);
    if (m_eru) chk("rdata_u", rdata_u, m_ed);
  end

  task automatic drv(input logic rc, input logic wc, input logic [31:0] ac, input logic [31:0] dc,
                     input logic [3:0] bc, input logic ru, input logic wu, input logic [31:0] au,
                     input logic [31:0] du, input logic [3:0] bu, input logic lk);
    req_c = rc; we_c = wc; addr_c = ac; wdata_c = dc; be_c = bc;
    req_u = ru; we_u = wu; addr_u = au; wdata_u = du; be_u = bu;
    lock_u = lk;
  endtask

  task automatic idle(input logic lk);
    drv(1'b0, $urandom_range(0, 1), $urandom, $urandom, 4'hF,
        1'b0, $urandom_range(0, 1), $urandom, $urandom, 4'hF, lk);
  endtask

  // Checks one cycle's grant and memory port against the expected winner,
  // records the expected response or write, then moves past the next edge.
  task automatic step(input logic egc, input logic egu);
    logic        ew;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    exp_t        e;
    @(negedge clk);
    if (egc)      begin ew = we_c; ea = addr_c; ed = wdata_c; eb = be_c; end
    else if (egu) begin ew = we_u; ea = addr_u; ed = wdata_u; eb = be_u; end
    else          begin ew = 1'b0; ea = '0;     ed = '0;      eb = '0;   end
    chk("gnt_c", gnt_c, egc);
    chk("gnt_u", gnt_u, egu);
    chk("mem_en", mem_en, egc | egu);
    chk("mem_we", mem_we, ew);
    chk("mem_addr", mem_addr, ea);
    if (ew) begin
      chk("mem_wdata", mem_wdata, ed);
      chk("mem_be", mem_be, eb);
      for (int b = 0; b < 4; b++)
        if (eb[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
    end else if (egc | egu) begin
      e.owner = egu;
      e.data  = ref_mem[ea[9:2]];
      e.cyc   = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE_0000 | (i * 4);
      ref_mem[i] = 32'hC0DE_0000 | (i * 4);
    end
    rst_n = 1'b0;
    drv(1'b1, 1'b1, 32'h10, 32'h1, 4'hF, 1'b1, 1'b1, 32'h20, 32'h2, 4'hF, 1'b0);
    @(negedge clk);
    chk("rst_gnt_c", gnt_c, 1'b0);
    chk("rst_gnt_u", gnt_u, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_lock_err", lock_err, 1'b0);
    @(posedge clk); #1;
    idle(1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after reset: core first, then alternate.
    drv(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(1'b0); step(1'b0, 1'b0);

    // Core streaming reads.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0);
    end
    idle(1'b0); step(1'b0, 1'b0);

    // Lock hold: rising cycle still arbitrates normally, then core is shut out.
    drv(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b1, 32'h200 + 32'(i * 4),
          32'hA000_0000 + 32'(i), 4'hF, 1'b1);
      step(1'b0, 1'b1);
    end
    drv(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("lock_err_after_hold", lock_err, 1'b0);
    idle(1'b0); step(1'b0, 1'b0);

    // Watchdog: LOCK_MAX=12 locked cycles, then one forced core grant.
    drv(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      chk("lock_err_locked", lock_err, 1'b0);
    end
    drv(1'b1, 1'b0, 32'hC, 32'h0, 4'hF, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1);
    step(1'b1, 1'b0);
    chk("lock_err_set", lock_err, 1'b1);
    step(1'b0, 1'b1);
    idle(1'b0); step(1'b0, 1'b0);
    idle(1'b0); step(1'b0, 1'b0);
    chk("lock_err_sticky", lock_err, 1'b1);

    // Write then read back, including a partial-byte write.
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0);
    step(1'b0, 1'b1);
    drv(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h104, 32'h1122_3344, 4'h3, 1'b0);
    step(1'b0, 1'b1);
    drv(1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0);
    idle(1'b0); step(1'b0, 1'b0);

    // Reset between a read grant and its response drops the response.
    drv(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("pre_rst_gnt_c", gnt_c, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt_c", gnt_c, 1'b0);
    chk("mid_rst_mem_en", mem_en, 1'b0);
    chk("mid_rst_rvalid_c", rvalid_c, 1'b0);
    chk("mid_rst_lock_err", lock_err, 1'b0);
    q.delete();
    idle(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drv(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(1'b0); step(1'b0, 1'b0);
    idle(1'b0); step(1'b0, 1'b0);

    chk("resp_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
